led_fade_pwm: RTL and testbench

Downstream LED output stage. Consumes the 6-bit on/off LED pattern produced by the LED shifter and drives the bank-3 LED pins with PWM. Each channel fades in fast and decays slowly, so the rotating pattern shows a trailing "comet". Runs on the 27 MHz crystal clock and sits between the pattern generator and the top-level pins.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_pwm_channel.sv | 71 +++++++
 rtl/led_fade_pwm.sv | 71 +++++++
 tb/tb_led_fade_pwm.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and the per-channel fade state encoding for the LED output stage.
package led_pkg;

   localparam int CLK_HZ        = 27_000_000;
   localparam int DEF_PWM_BITS  = 8;
   localparam int DEF_MAX_LEVEL = (1 << DEF_PWM_BITS) - 1;

   typedef enum logic [1:0] {
      CH_OFF,
      CH_RISE,
      CH_ON,
      CH_FALL
   } ch_state_t;

   function automatic ch_state_t ch_state(input logic req, input logic is_zero, input logic is_max);
      if (req) return is_max ? CH_ON : CH_RISE;
      else     return is_zero ? CH_OFF : CH_FALL;
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: saturating fade level, duty latch at period end, PWM comparator.
// Define LED_FADE_GAMMA_EN to square the level into the duty (full level kept always lit).
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS  = DEF_PWM_BITS,
   parameter int RISE_STEP = 32,
   parameter int FALL_STEP = 4
) (
   input  logic                clk_sys,
   input  logic                rst_b,
   input  logic                req,
   input  logic                fade_tick,
   input  logic                duty_load,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                lit
);

   localparam logic [PWM_BITS-1:0] MAX    = '1;
   localparam logic [PWM_BITS:0]   MAX_X  = {1'b0, MAX};
   localparam logic [PWM_BITS:0]   RISE_X = (PWM_BITS+1)'(RISE_STEP);
   localparam logic [PWM_BITS:0]   FALL_X = (PWM_BITS+1)'(FALL_STEP);

   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] level_nxt;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] duty_src;
   logic [PWM_BITS:0]   rise_sum;
   ch_state_t           state;

   // Extra top bit catches overflow on the way up; compare-before-subtract prevents underflow.
   always_comb begin
      rise_sum  = {1'b0, level} + RISE_X;
      level_nxt = level;
      if (req) begin
         level_nxt = (rise_sum > MAX_X) ? MAX : rise_sum[PWM_BITS-1:0];
      end else begin
         level_nxt = ({1'b0, level} < FALL_X) ? '0 : level - FALL_X[PWM_BITS-1:0];
      end
   end

`ifdef LED_FADE_GAMMA_EN
   logic [2*PWM_BITS-1:0] level_sq;

   always_comb begin
      level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
      duty_src = (level == MAX) ? MAX : level_sq[2*PWM_BITS-1:PWM_BITS];
   end
`else
   assign duty_src = level;
`endif

   assign state = ch_state(req, level == '0, level == MAX);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         level <= '0;
         duty  <= '0;
         lit   <= 1'b0;
      end else begin
         if (fade_tick) level <= level_nxt;
         if (duty_load) duty <= duty_src;
         lit <= (pwm_cnt < duty);
      end
   end

   // An idle channel with no request must stay dark.
   off_stays_off: assert property (@(posedge clk_sys) disable iff (!rst_b)
      (state == CH_OFF) |=> (level == '0));

endmodule

// File: rtl/led_fade_pwm.sv
// Bank-3 LED output stage: input register, fade prescaler, shared PWM counter, N_CH channels.
// Optional LED_FADE_GAMMA_EN selects the squared (perceptual) brightness map in each channel.
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int N_CH             = 6,
   parameter int PWM_BITS         = DEF_PWM_BITS,
   parameter int FADE_STEP_CYCLES = CLK_HZ / 1000,
   parameter int RISE_STEP        = 32,
   parameter int FALL_STEP        = 4,
   parameter bit IN_ACTIVE_LOW    = 1'b1,
   parameter bit OUT_ACTIVE_LOW   = 1'b1
) (
   input  logic            bank1_3v3_xtal_in,
   input  logic            bank3_1v8_sys_rst,
   input  logic [N_CH-1:0] led_in,
   output logic [N_CH-1:0] led_out,
   output logic            period_start
);

   localparam int                  PRE_W    = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_STEP_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
   localparam logic [N_CH-1:0]     IN_POL   = {N_CH{IN_ACTIVE_LOW}};
   localparam logic [N_CH-1:0]     OUT_POL  = {N_CH{OUT_ACTIVE_LOW}};

   logic [N_CH-1:0]     in_q;
   logic [N_CH-1:0]     req;
   logic [N_CH-1:0]     lit;
   logic [PRE_W-1:0]    pre_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                fade_tick;
   logic                duty_load;

   always_ff @(posedge bank1_3v3_xtal_in or negedge bank3_1v8_sys_rst) begin
      if (!bank3_1v8_sys_rst) begin
         in_q    <= IN_POL;
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else begin
         in_q    <= led_in;
         pre_cnt <= fade_tick ? '0 : pre_cnt + 1'b1;
         pwm_cnt <= duty_load ? '0 : pwm_cnt + 1'b1;
      end
   end

   assign fade_tick = (pre_cnt == PRE_LAST);
   assign duty_load = (pwm_cnt == PWM_LAST);
   assign req       = in_q ^ IN_POL;
   assign led_out   = lit ^ OUT_POL;

   // Gated by reset: low while held, high on the very first cycle after release.
   assign period_start = bank3_1v8_sys_rst && (pwm_cnt == '0);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS  (PWM_BITS),
         .RISE_STEP (RISE_STEP),
         .FALL_STEP (FALL_STEP)
      ) u_ch (
         .clk_sys   (bank1_3v3_xtal_in),
         .rst_b     (bank3_1v8_sys_rst),
         .req       (req[i]),
         .fade_tick (fade_tick),
         .duty_load (duty_load),
         .pwm_cnt   (pwm_cnt),
         .lit       (lit[i])
      );
   end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with PWM_BITS=4, 3-clock fade ticks, rise 8 / fall 2.
// Expected duties follow LED_FADE_GAMMA_EN when the bench is built with it defined.
module tb_led_fade_pwm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] led_in = 6'h3F;
   logic [5:0] led_out;
   logic       period_start;

   int n_checks = 0;
   int n_err    = 0;
   int lit_cnt [6];
   bit glitch  [6];

`ifdef LED_FADE_GAMMA_EN
   localparam int D8 = 4;
   localparam int D7 = 3;
`else
   localparam int D8 = 8;
   localparam int D7 = 7;
`endif

   led_fade_pwm #(
      .N_CH             (6),
      .PWM_BITS         (4),
      .FADE_STEP_CYCLES (3),
      .RISE_STEP        (8),
      .FALL_STEP        (2),
      .IN_ACTIVE_LOW    (1'b1),
      .OUT_ACTIVE_LOW   (1'b1)
   ) dut (
      .bank1_3v3_xtal_in (clk),
      .bank3_1v8_sys_rst (rst),
      .led_in            (led_in),
      .led_out           (led_out),
      .period_start      (period_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Samples one PWM period (15 negedges) starting from a negedge with pwm_cnt==0.
   task automatic measure_period(input int change_at, input logic [5:0] new_in);
      bit dark [6];
      for (int c = 0; c < 6; c++) begin
         lit_cnt[c] = 0;
         glitch[c]  = 1'b0;
         dark[c]    = 1'b0;
      end
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         for (int c = 0; c < 6; c++) begin
            if (led_out[c] == 1'b0) begin
               lit_cnt[c]++;
               if (dark[c]) glitch[c] = 1'b1;
            end else begin
               dark[c] = 1'b1;
            end
         end
         if (k == change_at) led_in = new_in;
      end
   endtask

   task automatic check_period(input string tag, input int exp0, input int exp_rest);
      check({tag, "_ch0_lit"}, lit_cnt[0], exp0);
      check({tag, "_ch0_glitch"}, int'(glitch[0]), 0);
      for (int c = 1; c < 6; c++) begin
         check($sformatf("%s_ch%0d_lit", tag, c), lit_cnt[c], exp_rest);
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      #1;
      check("rst_led_out", int'(led_out), 'h3F);
      check("rst_period_start", int'(period_start), 0);
      repeat (3) @(negedge clk);
      check("rst_led_out_held", int'(led_out), 'h3F);
      rst = 1'b1;
      #1 check("first_period_start", int'(period_start), 1);

      // ch0 requested at pwm_cnt 10: one rise tick lands before the coincident latch/tick at 14.
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         check($sformatf("ps_k%0d", k), int'(period_start), (k == 15) ? 1 : 0);
         if (k == 10) led_in = 6'h3E;
      end
      measure_period(0, 6'h3E); check_period("rise_p1", D8, 0);
      measure_period(0, 6'h3E); check_period("rise_p2", 15, 0);
      measure_period(0, 6'h3E); check_period("rise_p3", 15, 0);

      led_in = 6'h3F;
      measure_period(0, 6'h3F); check_period("fall_p4", 15, 0);
      measure_period(0, 6'h3F); check_period("fall_p5", D7, 0);
      measure_period(0, 6'h3F); check_period("fall_p6", 0, 0);
      measure_period(0, 6'h3F); check_period("fall_p7", 0, 0);

      led_in = 6'h3E;
      measure_period(0, 6'h3E); check_period("rev_p8", 0, 0);
      measure_period(0, 6'h3E); check_period("rev_p9", 15, 0);
      // Fall 15->13->11->9, request returns before the tick at pwm_cnt 11: 9+8 saturates to 15.
      led_in = 6'h3F;
      measure_period(10, 6'h3E); check_period("rev_p10", 15, 0);
      measure_period(0, 6'h3E);  check_period("rev_p11", 15, 0);

      led_in = 6'h00;
      measure_period(0, 6'h00); check_period("all_p12", 15, 0);
      measure_period(0, 6'h00); check_period("all_p13", 15, 15);
      repeat (5) @(negedge clk);
      check("all_lit_before_rst", int'(led_out), 'h00);

      #2 rst = 1'b0;
      led_in = 6'h3F;
      #1;
      check("midrun_rst_led_out", int'(led_out), 'h3F);
      check("midrun_rst_period_start", int'(period_start), 0);
      repeat (2) @(negedge clk);
      check("midrun_rst_led_out_held", int'(led_out), 'h3F);
      rst = 1'b1;
      #1 check("restart_period_start", int'(period_start), 1);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         check($sformatf("restart_ps_k%0d", k), int'(period_start), (k == 15) ? 1 : 0);
         check($sformatf("restart_dark_k%0d", k), int'(led_out), 'h3F);
      end
      measure_period(0, 6'h3F); check_period("restart_p1", 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
